// File: rtl/lab1_qsys_pio_led_out.sv
// Avalon-MM output PIO driving board LEDs, with a per-bit blink mask gated by a prescaled timer.
// Optional OUTSET/OUTCLR registers at addr 4/5 are enabled by defining LAB1_PIO_LED_SETCLR_EN.
module lab1_qsys_pio_led_out #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PRESCALE    = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned    PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrMask   = 3'd1;
  localparam logic [2:0] AddrPeriod = 3'd2;
  localparam logic [2:0] AddrStatus = 3'd3;
`ifdef LAB1_PIO_LED_SETCLR_EN
  localparam logic [2:0] AddrOutSet = 3'd4;
  localparam logic [2:0] AddrOutClr = 3'd5;
`endif

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [15:0]      period_q, period_d;
  logic [PsW-1:0]   ps_q, ps_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic             phase_q, phase_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic             period_wr;
  logic             tick;
  logic [WIDTH-1:0] wr_data;

  // Upper writedata bits are deliberately dropped for narrow instances.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_data   = writedata[WIDTH-1:0];
  assign period_wr = wr_en && (address == AddrPeriod);
  assign tick      = (period_q != 16'd0) && (ps_q == PsMax);

  // Register file next state
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        AddrData:   data_d   = wr_data;
        AddrMask:   mask_d   = wr_data;
        AddrPeriod: period_d = writedata[15:0];
`ifdef LAB1_PIO_LED_SETCLR_EN
        AddrOutSet: data_d   = data_q | wr_data;
        AddrOutClr: data_d   = data_q & ~wr_data;
`endif
        default:    ;
      endcase
    end
  end

  // Blink timer; a PERIOD write clears it on the same edge, overriding any tick.
  always_comb begin
    ps_d       = ps_q;
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    if (period_wr || (period_q == 16'd0)) begin
      ps_d       = '0;
      tick_cnt_d = '0;
      phase_d    = 1'b0;
    end else begin
      ps_d = tick ? '0 : ps_q + PsW'(1);
      if (tick) begin
        if (tick_cnt_q == period_q - 16'd1) begin
          tick_cnt_d = '0;
          phase_d    = ~phase_q;
        end else begin
          tick_cnt_d = tick_cnt_q + 16'd1;
        end
      end
    end
  end

  // Read mux, sampled every edge (no read strobe)
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrData:   readdata_d[WIDTH-1:0] = data_q;
      AddrMask:   readdata_d[WIDTH-1:0] = mask_q;
      AddrPeriod: readdata_d[15:0]      = period_q;
      AddrStatus: readdata_d            = {15'b0, phase_q, tick_cnt_q};
      default:    readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      period_q   <= '0;
      ps_q       <= '0;
      tick_cnt_q <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      ps_q       <= ps_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_q & ~(mask_q & {WIDTH{phase_q}});

endmodule

// File: tb/tb_lab1_qsys_pio_led_out.sv
// Directed self-checking bench for lab1_qsys_pio_led_out (WIDTH=8, RESET_VALUE=A5, PRESCALE=4).
module tb_lab1_qsys_pio_led_out;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int n_checks;
  int n_fails;

  lab1_qsys_pio_led_out #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (8'hA5),
    .PRESCALE    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    step();
    d = readdata;
  endtask

  logic [31:0] r;
  logic [7:0]  exp_out;
  int          ph;

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #1;
    check("rst_out", {24'b0, out_port}, 32'hA5);
    check("rst_rd", readdata, 32'h0);
    step();
    step();
    reset = 1'b0;

    rd(3'd0, r); check("rd_data_rst", r, 32'hA5);
    rd(3'd3, r); check("rd_status_rst", r, 32'h0);

    wr(3'd0, 32'h3C);
    check("out_after_wr", {24'b0, out_port}, 32'h3C);
    rd(3'd0, r); check("rd_data_3c", r, 32'h3C);

    // Upper writedata bits ignored
    wr(3'd0, 32'hFFFF_FF5A);
    rd(3'd0, r); check("rd_data_width", r, 32'h5A);
    wr(3'd6, 32'hFF);
    rd(3'd6, r); check("rd_addr6", r, 32'h0);
    rd(3'd0, r); check("addr6_no_effect", r, 32'h5A);

    // Blink: PRESCALE=4, PERIOD=2 -> 8 cycles per half-period
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h0F);
    wr(3'd2, 32'h2);
    address = 3'd3;
    for (int i = 0; i < 24; i++) begin
      ph = (i / 8) % 2;
      exp_out = (ph != 0) ? 8'hF0 : 8'hFF;
      check("blink_out", {24'b0, out_port}, {24'b0, exp_out});
      if (i >= 1) begin
        check("blink_status", readdata,
              {15'b0, 1'(((i - 1) / 8) % 2), 16'(((i - 1) / 4) % 2)});
      end
      step();
    end
    check("blink_phase1", {24'b0, out_port}, 32'hF0);

    // PERIOD=0 while phase=1 stops blinking
    wr(3'd2, 32'h0);
    check("period0_out", {24'b0, out_port}, 32'hFF);
    address = 3'd3;
    for (int i = 0; i < 100; i++) begin
      step();
      check("period0_status", readdata, 32'h0);
    end
    check("period0_out_hold", {24'b0, out_port}, 32'hFF);

    // Reset mid-blink with phase=1
    wr(3'd2, 32'h2);
    for (int i = 0; i < 9; i++) step();
    check("pre_reset_out", {24'b0, out_port}, 32'hF0);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async_out", {24'b0, out_port}, 32'hA5);
    step();
    reset = 1'b0;
    rd(3'd1, r); check("reset_mask", r, 32'h0);
    rd(3'd2, r); check("reset_period", r, 32'h0);
    rd(3'd0, r); check("reset_data", r, 32'hA5);
    check("reset_out_hold", {24'b0, out_port}, 32'hA5);

    // OUTSET / OUTCLR
    wr(3'd0, 32'h0F);
    wr(3'd4, 32'h30);
    rd(3'd0, r);
`ifdef LAB1_PIO_LED_SETCLR_EN
    check("outset", r, 32'h3F);
`else
    check("outset_ignored", r, 32'h0F);
`endif
    wr(3'd5, 32'h03);
    rd(3'd0, r);
`ifdef LAB1_PIO_LED_SETCLR_EN
    check("outclr", r, 32'h3C);
`else
    check("outclr_ignored", r, 32'h0F);
`endif
    rd(3'd4, r); check("rd_addr4", r, 32'h0);
    rd(3'd5, r); check("rd_addr5", r, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
